// File: rtl/mem_arbiter.sv
`default_nettype none
//==============================================================================
//  Module      : mem_arbiter
//  Description : Two-master round-robin arbiter for the valid/ready memory bus
//                (32-bit address/data, 4-bit write strobes). The grant is held
//                for a whole transaction. A bus watchdog completes any access
//                that the slave does not acknowledge within TIMEOUT cycles
//                with an error flag and ERR_RDATA.
//
//  Ports       : clk                 clock, all logic on the rising edge
//                rst                 asynchronous, active-low reset
//                m0_* / m1_*         master request/response channels
//                                    (valid, addr, wdata, wstrb in;
//                                     ready, rdata, err out)
//                s_*                 shared slave bus
//                                    (valid, addr, wdata, wstrb out;
//                                     ready, rdata in)
//
//  Revision    : 1.0  initial release
//==============================================================================
module mem_arbiter #(
    parameter int unsigned TIMEOUT   = 256,
    parameter logic [31:0] ERR_RDATA = 32'hDEADBEEF
) (
    input  logic        clk,
    input  logic        rst,

    input  logic        m0_valid,
    output logic        m0_ready,
    input  logic [31:0] m0_addr,
    input  logic [31:0] m0_wdata,
    input  logic [3:0]  m0_wstrb,
    output logic [31:0] m0_rdata,
    output logic        m0_err,

    input  logic        m1_valid,
    output logic        m1_ready,
    input  logic [31:0] m1_addr,
    input  logic [31:0] m1_wdata,
    input  logic [3:0]  m1_wstrb,
    output logic [31:0] m1_rdata,
    output logic        m1_err,

    output logic        s_valid,
    input  logic        s_ready,
    output logic [31:0] s_addr,
    output logic [31:0] s_wdata,
    output logic [3:0]  s_wstrb,
    input  logic [31:0] s_rdata
);

    localparam logic [1:0]  c_st_idle = 2'd0;
    localparam logic [1:0]  c_st_busy = 2'd1;
    localparam logic [1:0]  c_st_err  = 2'd2;

    localparam logic [15:0] c_timeout = 16'(TIMEOUT);
    localparam logic [15:0] c_trip    = c_timeout - 16'd1;
    localparam logic        c_wdog_en = (TIMEOUT != 0);
    localparam logic [15:0] c_cnt_max = 16'hFFFF;

    logic [1:0]  r_state;
    logic        r_grant;
    logic        r_last;
    logic [15:0] r_cnt;

    logic        w_busy;
    logic        w_err;
    logic        w_done;
    logic [31:0] w_resp_data;

    //--------------------------------------------------------------------------
    // Arbitration / transaction FSM
    //--------------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state <= c_st_idle;
            r_grant <= 1'b0;
            // last=1 so that a simultaneous request right after reset goes to m0
            r_last  <= 1'b1;
            r_cnt   <= 16'd0;
        end else begin
            case (r_state)
                c_st_idle: begin
                    if (m0_valid || m1_valid) begin
                        if (m0_valid && m1_valid) begin
                            r_grant <= ~r_last;
                        end else begin
                            r_grant <= m1_valid;
                        end
                        r_state <= c_st_busy;
                        r_cnt   <= 16'd0;
                    end
                end

                c_st_busy: begin
                    if (s_ready) begin
                        // A slave response in the trip cycle still wins
                        r_state <= c_st_idle;
                        r_last  <= r_grant;
                    end else begin
                        if (c_wdog_en && (r_cnt == c_trip)) begin
                            r_state <= c_st_err;
                        end
                        // Saturate so a disabled watchdog can never wrap into a trip
                        if (r_cnt != c_cnt_max) begin
                            r_cnt <= r_cnt + 16'd1;
                        end
                    end
                end

                c_st_err: begin
                    r_state <= c_st_idle;
                    r_last  <= r_grant;
                end

                default: begin
                    r_state <= c_st_idle;
                end
            endcase
        end
    end

    //--------------------------------------------------------------------------
    // Bus side: request only presented while BUSY, otherwise driven to zero
    //--------------------------------------------------------------------------
    assign w_busy = (r_state == c_st_busy);
    assign w_err  = (r_state == c_st_err);

    assign s_valid = w_busy;
    assign s_addr  = w_busy ? (r_grant ? m1_addr  : m0_addr)  : 32'd0;
    assign s_wdata = w_busy ? (r_grant ? m1_wdata : m0_wdata) : 32'd0;
    assign s_wstrb = w_busy ? (r_grant ? m1_wstrb : m0_wstrb) : 4'd0;

    //--------------------------------------------------------------------------
    // Master side: response routed only to the granted master
    //--------------------------------------------------------------------------
    assign w_done      = (w_busy && s_ready) || w_err;
    assign w_resp_data = w_err ? ERR_RDATA : s_rdata;

    assign m0_ready = w_done && !r_grant;
    assign m1_ready = w_done &&  r_grant;
    assign m0_rdata = m0_ready ? w_resp_data : 32'd0;
    assign m1_rdata = m1_ready ? w_resp_data : 32'd0;
    assign m0_err   = w_err && !r_grant;
    assign m1_err   = w_err &&  r_grant;

endmodule
`default_nettype wire

// File: tb/tb_mem_arbiter.sv
`default_nettype none
//==============================================================================
//  Module      : tb_mem_arbiter
//  Description : Self-checking bench for mem_arbiter. Master drivers push the
//                expected response of each request into a per-master queue;
//                a monitor pops and compares whenever a master sees ready,
//                and independently checks round-robin grant order and the
//                payload presented on the slave bus. The slave model answers
//                with an address-dependent latency and data.
//
//  Revision    : 1.0  initial release
//==============================================================================
module tb_mem_arbiter;

    localparam int          TO       = 4;
    localparam logic [31:0] ERR_DATA = 32'hDEADBEEF;

    logic        clk;
    logic        rst;
    logic        m0_valid, m0_ready, m0_err;
    logic [31:0] m0_addr, m0_wdata, m0_rdata;
    logic [3:0]  m0_wstrb;
    logic        m1_valid, m1_ready, m1_err;
    logic [31:0] m1_addr, m1_wdata, m1_rdata;
    logic [3:0]  m1_wstrb;
    logic        s_valid, s_ready;
    logic [31:0] s_addr, s_wdata, s_rdata;
    logic [3:0]  s_wstrb;

    typedef struct {
        logic [31:0] rdata;
        logic        err;
    } exp_t;

    exp_t q0[$];
    exp_t q1[$];

    int n_checks = 0;
    int n_pass   = 0;

    mem_arbiter #(
        .TIMEOUT   (TO),
        .ERR_RDATA (ERR_DATA)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .m0_valid (m0_valid),
        .m0_ready (m0_ready),
        .m0_addr  (m0_addr),
        .m0_wdata (m0_wdata),
        .m0_wstrb (m0_wstrb),
        .m0_rdata (m0_rdata),
        .m0_err   (m0_err),
        .m1_valid (m1_valid),
        .m1_ready (m1_ready),
        .m1_addr  (m1_addr),
        .m1_wdata (m1_wdata),
        .m1_wstrb (m1_wstrb),
        .m1_rdata (m1_rdata),
        .m1_err   (m1_err),
        .s_valid  (s_valid),
        .s_ready  (s_ready),
        .s_addr   (s_addr),
        .s_wdata  (s_wdata),
        .s_wstrb  (s_wstrb),
        .s_rdata  (s_rdata)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #500000;
        $display("FAIL global_timeout: simulation did not finish, got hang, expected completion");
        $fatal(1);
    end

    //--------------------------------------------------------------------------
    // Reference model: slave latency (BUSY cycles before s_ready) and data
    //--------------------------------------------------------------------------
    function automatic int slave_lat(input logic [31:0] a);
        if (a == 32'h0000_0010) return 2;
        if (a == 32'h0200_0000) return 1000;   // unmapped: never answers
        return int'(a[2:0]);
    endfunction

    function automatic logic [31:0] slave_data(input logic [31:0] a);
        if (a == 32'h0000_0010) return 32'h1234_5678;
        return a ^ 32'h5A5A_A5A5;
    endfunction

    // Response a master must see: data if the slave answers within TO cycles
    function automatic exp_t expect_resp(input logic [31:0] a);
        exp_t e;
        if (slave_lat(a) < TO) begin
            e.rdata = slave_data(a);
            e.err   = 1'b0;
        end else begin
            e.rdata = ERR_DATA;
            e.err   = 1'b1;
        end
        return e;
    endfunction

    task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h, expected %0h (t=%0t)", nm, act, exp, $time);
    endtask

    //--------------------------------------------------------------------------
    // Slave model
    //--------------------------------------------------------------------------
    initial begin
        int cnt;
        cnt     = 0;
        s_ready = 1'b0;
        s_rdata = 32'd0;
        forever begin
            @(posedge clk);
            #1;
            if (s_valid) begin
                if (cnt == slave_lat(s_addr)) begin
                    s_ready = 1'b1;
                    s_rdata = slave_data(s_addr);
                end else begin
                    s_ready = 1'b0;
                    s_rdata = $urandom;
                end
                cnt++;
            end else begin
                // noise on an idle bus must be ignored by the arbiter
                s_ready = 1'($urandom_range(0, 1));
                s_rdata = $urandom;
                cnt     = 0;
            end
        end
    end

    //--------------------------------------------------------------------------
    // Monitor / scoreboard
    //--------------------------------------------------------------------------
    task automatic on_ready(input int m, input int owner);
        exp_t e;
        logic [31:0] rd;
        logic        er, oth_rd_zero;
        rd          = (m == 0) ? m0_rdata : m1_rdata;
        er          = (m == 0) ? m0_err   : m1_err;
        oth_rd_zero = (m == 0) ? (m1_rdata == 32'd0 && !m1_ready) : (m0_rdata == 32'd0 && !m0_ready);
        check($sformatf("granted_master_m%0d", m), 64'(owner), 64'(m));
        check($sformatf("other_idle_m%0d", m), 64'(oth_rd_zero), 64'd1);
        if ((m == 0 ? q0.size() : q1.size()) == 0) begin
            check($sformatf("unexpected_ready_m%0d", m), 64'd1, 64'd0);
        end else begin
            e = (m == 0) ? q0.pop_front() : q1.pop_front();
            check($sformatf("rdata_m%0d", m), 64'(rd), 64'(e.rdata));
            check($sformatf("err_m%0d", m), 64'(er), 64'(e.err));
            check($sformatf("s_valid_at_done_m%0d", m), 64'(s_valid), 64'(!e.err));
        end
    endtask

    initial begin
        int   owner, last, win;
        logic pv, pr0, pr1, pdone;
        owner = -1; last = 1; pv = 0; pr0 = 0; pr1 = 0; pdone = 0;
        forever begin
            @(negedge clk);
            if (!rst) begin
                owner = -1; last = 1; pv = 0; pdone = 0;
            end else begin
                if (pdone) check("idle_bubble_after_done", 64'(s_valid), 64'd0);
                if (s_valid && !pv) begin
                    // Requests seen in the arbitration cycle decide the winner
                    if (pr0 && pr1)  win = 1 - last;
                    else if (pr1)    win = 1;
                    else if (pr0)    win = 0;
                    else             win = -1;
                    if (win < 0) check("spurious_grant", 64'd1, 64'd0);
                    owner = win;
                end
                if (s_valid) begin
                    if (owner == 0) begin
                        check("s_addr_m0", 64'(s_addr), 64'(m0_addr));
                        check("s_wdata_wstrb_m0", {28'd0, s_wdata, s_wstrb}, {28'd0, m0_wdata, m0_wstrb});
                    end else if (owner == 1) begin
                        check("s_addr_m1", 64'(s_addr), 64'(m1_addr));
                        check("s_wdata_wstrb_m1", {28'd0, s_wdata, s_wstrb}, {28'd0, m1_wdata, m1_wstrb});
                    end
                end else begin
                    check("s_payload_zero_when_idle", {28'd0, s_addr, s_wstrb}, 64'd0);
                end
                if (m0_ready) begin on_ready(0, owner); last = 0; end
                if (m1_ready) begin on_ready(1, owner); last = 1; end
                pdone = m0_ready || m1_ready;
                pv    = s_valid;
            end
            pr0 = m0_valid;
            pr1 = m1_valid;
        end
    end

    //--------------------------------------------------------------------------
    // Master driver: one transaction, returns the number of cycles from
    // raising valid up to and including the ready cycle
    //--------------------------------------------------------------------------
    task automatic do_txn(input int m, input logic [31:0] a, input logic [31:0] wd,
                          input logic [3:0] ws, output int cyc);
        logic got;
        if (m == 0) begin
            q0.push_back(expect_resp(a));
            m0_addr = a; m0_wdata = wd; m0_wstrb = ws; m0_valid = 1'b1;
        end else begin
            q1.push_back(expect_resp(a));
            m1_addr = a; m1_wdata = wd; m1_wstrb = ws; m1_valid = 1'b1;
        end
        cyc = 0;
        got = 1'b0;
        while (!got && cyc < 200) begin
            @(negedge clk);
            cyc++;
            got = (m == 0) ? m0_ready : m1_ready;
        end
        if (!got) check($sformatf("ready_timeout_m%0d", m), 64'd0, 64'd1);
        @(posedge clk);
        #1;
        if (m == 0) m0_valid = 1'b0;
        else        m1_valid = 1'b0;
    endtask

    task automatic reset_pulse();
        rst = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b1;
    endtask

    //--------------------------------------------------------------------------
    // Main sequence
    //--------------------------------------------------------------------------
    initial begin
        int c0, c1;
        rst = 1'b0;
        m0_valid = 0; m0_addr = 0; m0_wdata = 0; m0_wstrb = 0;
        m1_valid = 0; m1_addr = 0; m1_wdata = 0; m1_wstrb = 0;
        repeat (3) @(posedge clk);
        #1;
        check("reset_s_valid", 64'(s_valid), 64'd0);
        check("reset_ready_err", {60'd0, m0_ready, m1_ready, m0_err, m1_err}, 64'd0);
        check("reset_rdata", {m0_rdata, m1_rdata}, 64'd0);
        rst = 1'b1;

        // Single m0 read, slave answers in the 3rd BUSY cycle
        fork
            do_txn(0, 32'h0000_0010, 32'd0, 4'd0, c0);
            begin
                @(negedge clk);
                check("t1_no_valid_in_arb_cycle", 64'(s_valid), 64'd0);
                @(negedge clk);
                check("t1_valid_one_cycle_later", {31'd0, s_valid, s_addr}, {31'd0, 1'b1, 32'h0000_0010});
            end
        join
        check("t1_latency", 64'(c0), 64'd4);

        // Both masters from reset, repeating, zero-latency slave
        reset_pulse();
        fork
            repeat (2) do_txn(0, 32'h0000_1000, 32'h0, 4'h0, c0);
            repeat (2) do_txn(1, 32'h1000_2000, 32'hA5A5_A5A5, 4'hF, c1);
        join

        // m1 request arrives while m0 is BUSY
        fork
            do_txn(0, 32'h0000_0103, 32'h1111_1111, 4'h3, c0);
            begin
                repeat (2) @(posedge clk);
                #1;
                do_txn(1, 32'h1000_0301, 32'h2222_2222, 4'h1, c1);
            end
        join

        // Watchdog trip on unmapped address
        do_txn(1, 32'h0200_0000, 32'd0, 4'd0, c1);
        check("t4_timeout_latency", 64'(c1), 64'(TO + 2));

        // Slave answers in the last permitted BUSY cycle
        do_txn(0, 32'h0000_0203, 32'd0, 4'd0, c0);
        check("t5_boundary_latency", 64'(c0), 64'(TO + 1));

        // Reset during BUSY with both requesting
        fork
            do_txn(0, 32'h0000_0403, 32'h3333_3333, 4'h2, c0);
            do_txn(1, 32'h1000_0503, 32'h4444_4444, 4'h4, c1);
            begin
                repeat (3) @(posedge clk);
                #3;
                rst = 1'b0;
                #1;
                check("t6_reset_s_valid", {31'd0, s_valid, s_addr}, 64'd0);
                check("t6_reset_ready", {62'd0, m0_ready, m1_ready}, 64'd0);
                @(posedge clk);
                #3;
                rst = 1'b1;
            end
        join

        // Randomised traffic from both masters
        fork
            for (int i = 0; i < 30; i++) begin
                int cr;
                repeat ($urandom_range(0, 2)) @(posedge clk);
                #0;
                do_txn(0, ($urandom & 32'h0FFF_FFF8) | 32'($urandom_range(0, 5)),
                       $urandom, 4'($urandom), cr);
            end
            for (int j = 0; j < 30; j++) begin
                int cr;
                repeat ($urandom_range(0, 2)) @(posedge clk);
                #0;
                do_txn(1, ($urandom & 32'h0FFF_FFF8) | 32'h1000_0000 | 32'($urandom_range(0, 5)),
                       $urandom, 4'($urandom), cr);
            end
        join

        repeat (3) @(negedge clk);
        check("scoreboard_m0_drained", 64'(q0.size()), 64'd0);
        check("scoreboard_m1_drained", 64'(q1.size()), 64'd0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
`default_nettype wire
